// File: rtl/usb_pkg.sv
// Shared USB link definitions: receive FSM states, PID codes, SYNC pattern.
package usb_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RCV_SYNC,
      CHK_SYNC,
      RCV_PID,
      CHK_PID,
      RCV_DATA,
      STORE_BYTE,
      CHK_EOP,
      WAIT_EOP,
      DONE,
      ERR_WAIT
   } rx_state_t;

   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;

   // SYNC as it appears in an LSB-first shift register (seven 0s then a 1)
   localparam logic [7:0] USB_SYNC     = 8'h80;
   localparam int         USB_MAX_DATA = 64;

   // A PID byte is valid when its upper nibble is the complement of the lower one
   function automatic logic pid_check_ok(input logic [7:0] pid_byte);
      return pid_byte[7:4] == ~pid_byte[3:0];
   endfunction

endpackage

// File: rtl/usb_rx_bit_counter.sv
// Counts decoded bits within a byte and flags the eighth bit.
module usb_rx_bit_counter (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       clear,
   input  logic       enable,
   output logic [2:0] cnt,
   output logic       byte_done
);

   // Bit position 0..7; a clear (packet start) takes priority over counting
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + 3'd1;
   end

   assign byte_done = enable && (cnt == 3'd7);

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB receive packet control: SYNC/PID checking, payload streaming with the
// trailing CRC16 stripped by a 2-byte holding pipe, handshake reporting.
module usb_rx_ctrl
   import usb_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = USB_SYNC,
   parameter int         MAX_DATA_BYTES = USB_MAX_DATA
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_edge,
   input  logic       eop,
   input  logic       shift_enable,
   input  logic [7:0] rcv_byte,
   input  logic       crc_ok,
   output logic       rcving,
   output logic       w_enable,
   output logic [7:0] rx_data,
   output logic [3:0] rx_pid,
   output logic       rx_ack,
   output logic       rx_nack,
   output logic       rx_stall,
   output logic       rx_packet_done,
   output logic       r_error,
   output logic [6:0] byte_count
);

   rx_state_t  state;
   logic [2:0] cnt;
   logic       byte_done;
   logic       start;
   logic [7:0] hold0;
   logic [7:0] hold1;
   logic [1:0] hcnt;
   logic       crc_reg;

   // Only a d_edge accepted in IDLE starts a packet and realigns the bit counter
   assign start = d_edge && (state == IDLE);

   usb_rx_bit_counter u_bit_counter (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (start),
      .enable    (shift_enable),
      .cnt       (cnt),
      .byte_done (byte_done)
   );

   // Packet FSM with hold pipe, byte counter and all registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state          <= IDLE;
         rcving         <= 1'b0;
         w_enable       <= 1'b0;
         rx_data        <= '0;
         rx_pid         <= '0;
         rx_ack         <= 1'b0;
         rx_nack        <= 1'b0;
         rx_stall       <= 1'b0;
         rx_packet_done <= 1'b0;
         r_error        <= 1'b0;
         byte_count     <= '0;
         hold0          <= '0;
         hold1          <= '0;
         hcnt           <= '0;
         crc_reg        <= 1'b0;
      end else begin
         w_enable       <= 1'b0;
         rx_ack         <= 1'b0;
         rx_nack        <= 1'b0;
         rx_stall       <= 1'b0;
         rx_packet_done <= 1'b0;
         case (state)
            IDLE: begin
               if (d_edge) begin
                  state      <= RCV_SYNC;
                  rcving     <= 1'b1;
                  r_error    <= 1'b0;
                  byte_count <= '0;
                  hcnt       <= '0;
               end
            end
            RCV_SYNC: begin
               if (eop) begin
                  state   <= IDLE;
                  rcving  <= 1'b0;
                  r_error <= 1'b1;
               end else if (byte_done) begin
                  state <= CHK_SYNC;
               end
            end
            CHK_SYNC: begin
               if (rcv_byte == SYNC_BYTE) begin
                  state <= RCV_PID;
               end else begin
                  state   <= ERR_WAIT;
                  r_error <= 1'b1;
               end
            end
            RCV_PID: begin
               if (eop) begin
                  state   <= IDLE;
                  rcving  <= 1'b0;
                  r_error <= 1'b1;
               end else if (byte_done) begin
                  state <= CHK_PID;
               end
            end
            CHK_PID: begin
               if (!pid_check_ok(rcv_byte)) begin
                  state   <= ERR_WAIT;
                  r_error <= 1'b1;
               end else begin
                  rx_pid <= rcv_byte[3:0];
                  case (rcv_byte[3:0])
                     PID_ACK, PID_NAK, PID_STALL: state <= WAIT_EOP;
                     PID_DATA0, PID_DATA1:        state <= RCV_DATA;
                     default: begin
                        state   <= ERR_WAIT;
                        r_error <= 1'b1;
                     end
                  endcase
               end
            end
            RCV_DATA: begin
               // eop outranks a simultaneous byte_done; only a byte-aligned eop is clean
               if (eop) begin
                  if (cnt == 3'd0) begin
                     state   <= CHK_EOP;
                     crc_reg <= crc_ok;
                  end else begin
                     state   <= IDLE;
                     rcving  <= 1'b0;
                     r_error <= 1'b1;
                  end
               end else if (byte_done) begin
                  state <= STORE_BYTE;
               end
            end
            STORE_BYTE: begin
               // The two newest bytes stay held so the CRC16 never reaches the FIFO
               if (hcnt == 2'd2) begin
                  if (byte_count == 7'(MAX_DATA_BYTES)) begin
                     state   <= ERR_WAIT;
                     r_error <= 1'b1;
                  end else begin
                     state      <= RCV_DATA;
                     w_enable   <= 1'b1;
                     rx_data    <= hold1;
                     byte_count <= byte_count + 7'd1;
                     hold1      <= hold0;
                     hold0      <= rcv_byte;
                  end
               end else begin
                  state <= RCV_DATA;
                  hcnt  <= hcnt + 2'd1;
                  hold1 <= hold0;
                  hold0 <= rcv_byte;
               end
            end
            CHK_EOP: begin
               if (hcnt == 2'd2 && crc_reg) begin
                  state <= DONE;
               end else begin
                  state   <= IDLE;
                  rcving  <= 1'b0;
                  r_error <= 1'b1;
               end
            end
            WAIT_EOP: begin
               if (eop) begin
                  state <= DONE;
               end else if (byte_done) begin
                  state   <= ERR_WAIT;
                  r_error <= 1'b1;
               end
            end
            DONE: begin
               state          <= IDLE;
               rcving         <= 1'b0;
               rx_packet_done <= 1'b1;
               rx_ack         <= (rx_pid == PID_ACK);
               rx_nack        <= (rx_pid == PID_NAK);
               rx_stall       <= (rx_pid == PID_STALL);
            end
            ERR_WAIT: begin
               r_error <= 1'b1;
               if (eop) begin
                  state  <= IDLE;
                  rcving <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               rcving <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Scoreboard bench for usb_rx_ctrl: stimulus pushes expected FIFO writes and
// completion events; a negedge monitor pops and compares them.
module tb_usb_rx_ctrl;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       d_edge = 1'b0;
   logic       eop = 1'b0;
   logic       shift_enable = 1'b0;
   logic [7:0] rcv_byte = 8'h00;
   logic       crc_ok = 1'b0;
   logic       rcving, w_enable, rx_ack, rx_nack, rx_stall, rx_packet_done, r_error;
   logic [7:0] rx_data;
   logic [3:0] rx_pid;
   logic [6:0] byte_count;

   int checks = 0;
   int failures = 0;
   int wr_seen = 0;

   // expected event: {pid, ack, nack, stall, done, byte_count}
   logic [7:0]  exp_wr[$];
   logic [14:0] exp_evt[$];
   logic [7:0]  mon_byte;
   logic [14:0] mon_evt;

   usb_rx_ctrl dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .d_edge         (d_edge),
      .eop            (eop),
      .shift_enable   (shift_enable),
      .rcv_byte       (rcv_byte),
      .crc_ok         (crc_ok),
      .rcving         (rcving),
      .w_enable       (w_enable),
      .rx_data        (rx_data),
      .rx_pid         (rx_pid),
      .rx_ack         (rx_ack),
      .rx_nack        (rx_nack),
      .rx_stall       (rx_stall),
      .rx_packet_done (rx_packet_done),
      .r_error        (r_error),
      .byte_count     (byte_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every output transaction is matched against the scoreboard
   always @(negedge clk) begin
      if (n_rst) begin
         if (w_enable) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
               chk("unexpected_write", {24'h0, rx_data}, 32'hFFFF_FFFF);
            end else begin
               mon_byte = exp_wr.pop_front();
               chk("rx_data", {24'h0, rx_data}, {24'h0, mon_byte});
               $display("write rx_data=%02h expected=%02h byte_count=%0d", rx_data, mon_byte, byte_count);
            end
         end
         if (rx_packet_done || rx_ack || rx_nack || rx_stall) begin
            if (exp_evt.size() == 0) begin
               chk("unexpected_event", {17'h0, rx_pid, rx_ack, rx_nack, rx_stall, rx_packet_done, byte_count}, 32'hFFFF_FFFF);
            end else begin
               mon_evt = exp_evt.pop_front();
               chk("event", {17'h0, rx_pid, rx_ack, rx_nack, rx_stall, rx_packet_done, byte_count}, {17'h0, mon_evt});
               $display("event pid=%h ack=%b nak=%b stall=%b done=%b byte_count=%0d", rx_pid, rx_ack, rx_nack,
                        rx_stall, rx_packet_done, byte_count);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One decoded bit: shift_enable pulse, shift register updates after the edge, then a gap cycle
   task automatic send_bit(input logic b);
      shift_enable = 1'b1;
      @(negedge clk);
      shift_enable = 1'b0;
      rcv_byte = {b, rcv_byte[7:1]};
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
   endtask

   task automatic start_pkt();
      wr_seen = 0;
      d_edge = 1'b1;
      @(negedge clk);
      d_edge = 1'b0;
   endtask

   task automatic send_eop(input logic c);
      eop = 1'b1;
      crc_ok = c;
      @(negedge clk);
      eop = 1'b0;
      crc_ok = 1'b0;
   endtask

   task automatic push_evt(input logic [3:0] pid, input logic a, input logic n, input logic s, input logic [6:0] bc);
      exp_evt.push_back({pid, a, n, s, 1'b1, bc});
   endtask

   task automatic finish_pkt(input string name, input logic exp_err, input int exp_bc, input int exp_writes);
      cyc(4);
      chk({name, "_r_error"}, {31'h0, r_error}, {31'h0, exp_err});
      chk({name, "_byte_count"}, {25'h0, byte_count}, exp_bc);
      chk({name, "_rcving"}, {31'h0, rcving}, 32'h0);
      chk({name, "_writes"}, wr_seen, exp_writes);
      chk({name, "_pending_writes"}, exp_wr.size(), 32'h0);
      chk({name, "_pending_events"}, exp_evt.size(), 32'h0);
      $display("packet %s: r_error=%b byte_count=%0d writes=%0d", name, r_error, byte_count, wr_seen);
   endtask

   task automatic check_outputs_zero(input string name);
      chk(name, {8'h0, rcving, w_enable, rx_data, rx_pid, rx_ack, rx_nack, rx_stall, rx_packet_done, r_error,
                 byte_count}, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(2);
      check_outputs_zero("reset_outputs");
      n_rst = 1'b1;
      cyc(2);

      // ACK handshake
      start_pkt();
      chk("ack_rcving_started", {31'h0, rcving}, 32'h1);
      send_byte(8'h80);
      send_byte(8'hD2);
      push_evt(4'h2, 1'b1, 1'b0, 1'b0, 7'd0);
      send_eop(1'b0);
      finish_pkt("ack", 1'b0, 0, 0);

      // NAK and STALL handshakes
      start_pkt();
      send_byte(8'h80);
      send_byte(8'h5A);
      push_evt(4'hA, 1'b0, 1'b1, 1'b0, 7'd0);
      send_eop(1'b0);
      finish_pkt("nak", 1'b0, 0, 0);

      start_pkt();
      send_byte(8'h80);
      send_byte(8'h1E);
      push_evt(4'hE, 1'b0, 1'b0, 1'b1, 7'd0);
      send_eop(1'b0);
      finish_pkt("stall", 1'b0, 0, 0);

      // DATA0 with three payload bytes and good CRC
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      exp_wr.push_back(8'h11);
      exp_wr.push_back(8'h22);
      exp_wr.push_back(8'h33);
      push_evt(4'h3, 1'b0, 1'b0, 1'b0, 7'd3);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'hAB);
      send_byte(8'hCD);
      send_eop(1'b1);
      finish_pkt("data0_good", 1'b0, 3, 3);

      // Same packet with a bad CRC: bytes still written, no completion
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      exp_wr.push_back(8'h11);
      exp_wr.push_back(8'h22);
      exp_wr.push_back(8'h33);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'hAB);
      send_byte(8'hCD);
      send_eop(1'b0);
      finish_pkt("data0_bad_crc", 1'b1, 3, 3);

      // Bad PID check nibble: rest of the packet ignored until eop
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC2);
      send_byte(8'h11);
      send_byte(8'h22);
      send_eop(1'b1);
      finish_pkt("bad_pid", 1'b1, 0, 0);

      // Next good ACK clears the sticky error
      start_pkt();
      chk("ack_clears_r_error", {31'h0, r_error}, 32'h0);
      send_byte(8'h80);
      send_byte(8'hD2);
      push_evt(4'h2, 1'b1, 1'b0, 1'b0, 7'd0);
      send_eop(1'b0);
      finish_pkt("ack_after_err", 1'b0, 0, 0);

      // Bad SYNC
      start_pkt();
      send_byte(8'h81);
      send_byte(8'hD2);
      send_eop(1'b0);
      finish_pkt("bad_sync", 1'b1, 0, 0);

      // eop in the middle of a data byte
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      send_eop(1'b1);
      chk("partial_byte_r_error", {31'h0, r_error}, 32'h1);
      chk("partial_byte_idle", {31'h0, rcving}, 32'h0);
      finish_pkt("partial_byte", 1'b1, 0, 0);

      // Zero-length DATA1 (CRC only)
      start_pkt();
      send_byte(8'h80);
      send_byte(8'h4B);
      push_evt(4'hB, 1'b0, 1'b0, 1'b0, 7'd0);
      send_byte(8'h00);
      send_byte(8'h00);
      send_eop(1'b1);
      finish_pkt("zero_len", 1'b0, 0, 0);

      // Oversize payload: 64 writes, error on the 65th
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      for (int i = 1; i <= 64; i++) exp_wr.push_back(8'(i));
      for (int i = 1; i <= 67; i++) send_byte(8'(i));
      chk("oversize_r_error_early", {31'h0, r_error}, 32'h1);
      send_eop(1'b1);
      finish_pkt("oversize", 1'b1, 64, 64);

      // Reset in the middle of a payload
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      exp_wr.push_back(8'hAA);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      n_rst = 1'b0;
      #1;
      check_outputs_zero("reset_mid_packet_async");
      cyc(2);
      check_outputs_zero("reset_mid_packet_held");
      chk("reset_writes_before", wr_seen, 32'h1);
      rcv_byte = 8'h00;
      n_rst = 1'b1;
      cyc(2);
      check_outputs_zero("after_reset_release");

      // Clean DATA1 after reset
      start_pkt();
      send_byte(8'h80);
      send_byte(8'h4B);
      exp_wr.push_back(8'h5A);
      exp_wr.push_back(8'hA5);
      push_evt(4'hB, 1'b0, 1'b0, 1'b0, 7'd2);
      send_byte(8'h5A);
      send_byte(8'hA5);
      send_byte(8'h12);
      send_byte(8'h34);
      send_eop(1'b1);
      finish_pkt("data1_after_reset", 1'b0, 2, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
